// File: rtl/ad7476_pkg.sv
// Shared constants and FSM state type for the AD7476 serial responder.
package ad7476_pkg;
  localparam int AD_LEAD_ZEROS = 4;
  localparam int AD_DATA_BITS  = 12;
  localparam int AD_FRAME_BITS = 16;
  localparam int AD_CNT_W      = $clog2(AD_FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} ad_state_e;
endpackage

// File: rtl/ad7476_emu_sync_edge_det.sv
// Multi-flop synchronizer plus one-register edge detector for an asynchronous pin.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to 0 so a pin already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;
endmodule

// File: rtl/ad7476_emu.sv
// AD7476 ADC slave emulator: shifts 4 zeros + 12-bit sample MSB-first on sda per scs frame.
// Optional macro AD7476_EMU_RAMP_EN replaces the loaded sample with a ramp that advances per done.
module ad7476_emu
  import ad7476_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scs,
  input  logic                    sck,
  output logic                    sda,
  output logic                    sda_oe,
  input  logic [AD_DATA_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_rdy,
  output logic                    busy,
  output logic                    done,
  output logic                    abort
);
  localparam logic [AD_CNT_W-1:0] CNT_LAST = AD_CNT_W'(AD_FRAME_BITS - 1);

  logic [1:0] pin_lvl, pin_rise, pin_fall;
  logic       cs_fall, cs_rise, sck_fall;

  // Index 1 is scs, index 0 is sck.
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync [1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({scs, sck}),
    .lvl  (pin_lvl),
    .rise (pin_rise),
    .fall (pin_fall)
  );

  assign cs_fall  = pin_fall[1];
  assign cs_rise  = pin_rise[1];
  assign sck_fall = pin_fall[0];

  ad_state_e                  state_q, state_nxt;
  logic [AD_CNT_W-1:0]        cnt_q, cnt_nxt;
  logic [AD_FRAME_BITS-1:0]   shreg_q, shreg_nxt;
  logic                       sda_q, sda_nxt, oe_q, oe_nxt;
  logic                       done_q, done_nxt, abort_q, abort_nxt;
  logic [AD_DATA_BITS-1:0]    src;

`ifdef AD7476_EMU_RAMP_EN
  logic [AD_DATA_BITS-1:0] ramp_q;
  logic                    unused_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ramp_q <= '0;
    else if (done_nxt) ramp_q <= ramp_q + 1'b1;
  end

  assign src       = ramp_q;
  assign din_rdy   = 1'b0;
  assign unused_in = ^{din, din_vld, pin_lvl, pin_rise[0], pin_fall[1]};
`else
  logic [AD_DATA_BITS-1:0] hold_q;
  logic                    unused_in;

  // A load coinciding with cs_fall lands after shreg samples hold, so it goes to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  hold_q <= '0;
    else if (din_vld && din_rdy) hold_q <= din;
  end

  assign src       = hold_q;
  assign din_rdy   = 1'b1;
  assign unused_in = ^{pin_lvl, pin_rise[0], pin_fall[1]};
`endif

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shreg_nxt = shreg_q;
    sda_nxt   = sda_q;
    oe_nxt    = oe_q;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    unique case (state_q)
      IDLE: if (cs_fall) begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
        shreg_nxt = {{AD_LEAD_ZEROS{1'b0}}, src};
        sda_nxt   = shreg_nxt[AD_FRAME_BITS-1];
        oe_nxt    = 1'b1;
      end
      // cs_rise has priority, so a rise together with the 16th fall is still an abort.
      SHIFT: if (cs_rise) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sda_nxt   = 1'b0;
        oe_nxt    = 1'b0;
        abort_nxt = 1'b1;
      end else if (sck_fall) begin
        if (cnt_q == CNT_LAST) begin
          state_nxt = TAIL;
          oe_nxt    = 1'b0;
        end else begin
          shreg_nxt = {shreg_q[AD_FRAME_BITS-2:0], 1'b0};
          cnt_nxt   = cnt_q + 1'b1;
          sda_nxt   = shreg_q[AD_FRAME_BITS-2];
        end
      end
      TAIL: if (cs_rise) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sda_nxt   = 1'b0;
        oe_nxt    = 1'b0;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        oe_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sda_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      shreg_q <= shreg_nxt;
      sda_q   <= sda_nxt;
      oe_q    <= oe_nxt;
      done_q  <= done_nxt;
      abort_q <= abort_nxt;
    end
  end

  assign sda    = sda_q;
  assign sda_oe = oe_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign abort  = abort_q;
endmodule

// File: tb/tb_ad7476_emu.sv
// Scoreboard bench: a behavioural 3-wire master captures frames and compares against queued samples.
module tb_ad7476_emu;
  localparam int HP = 40;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        scs = 1'b1, sck = 1'b1;
  logic        sda, sda_oe, din_rdy, busy, done, abort;
  logic [11:0] din = '0;
  logic        din_vld = 1'b0;

  int checks = 0, errors = 0;
  int done_cnt = 0, abort_cnt = 0;
  logic [15:0] sb[$];
  logic [11:0] model_src = '0;

  ad7476_emu #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scs(scs), .sck(sck), .sda(sda), .sda_oe(sda_oe),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (abort) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [11:0] v);
    din = v; din_vld = 1'b1;
    #10;
    din_vld = 1'b0;
`ifndef AD7476_EMU_RAMP_EN
    model_src = v;
`endif
  endtask

  // nfalls >= 16 is a complete frame; race loads race_val in the cycle cs_fall is seen.
  task automatic frame(input string tag, input int nfalls, input bit race, input logic [11:0] race_val);
    int d0, a0;
    logic [15:0] cap, exp;
    bit full;
    d0 = done_cnt; a0 = abort_cnt; cap = '0; full = (nfalls >= 16);
    if (full) sb.push_back({4'h0, model_src});
    scs = 1'b0;
    if (race) begin
      #13; din = race_val; din_vld = 1'b1;
      #10; din_vld = 1'b0;
      model_src = race_val;
      #(HP - 23);
    end else #HP;
    chk({tag, ".busy"}, busy, 1);
    for (int i = 0; i < nfalls; i++) begin
      if (i < 16) cap = {cap[14:0], sda};
      sck = 1'b0; #HP;
      sck = 1'b1;
      if (i == 15) chk({tag, ".oe_drop"}, sda_oe, 0);
      #HP;
    end
    scs = 1'b1; #HP;
    if (full) begin
      exp = sb.pop_front();
      chk({tag, ".data"}, cap, exp);
      chk({tag, ".done"}, done_cnt - d0, 1);
      chk({tag, ".abort"}, abort_cnt - a0, 0);
`ifdef AD7476_EMU_RAMP_EN
      model_src = model_src + 1'b1;
`endif
    end else begin
      chk({tag, ".abort"}, abort_cnt - a0, 1);
      chk({tag, ".done"}, done_cnt - d0, 0);
    end
    chk({tag, ".idle"}, {busy, sda_oe}, 0);
    #HP;
  endtask

  initial begin
    #22 rst_n = 1'b1;
    @(posedge clk); #8;  // inputs change 2 ns before posedges from here on
    chk("rst.sda", sda, 0);
    chk("rst.oe", sda_oe, 0);
    chk("rst.busy", busy, 0);
    chk("rst.pulses", {done, abort}, 0);
`ifdef AD7476_EMU_RAMP_EN
    chk("rst.rdy", din_rdy, 0);
    load(12'hA5C);
    for (int f = 0; f < 3; f++) frame("ramp", 16, 1'b0, 12'h0);
    frame("ramp_abort", 8, 1'b0, 12'h0);
    for (int f = 0; f < 2; f++) frame("ramp", 16, 1'b0, 12'h0);
`else
    chk("rst.rdy", din_rdy, 1);
    load(12'hA5C);
    frame("full", 16, 1'b0, 12'h0);
    frame("abort", 8, 1'b0, 12'h0);
    frame("after_abort", 16, 1'b0, 12'h0);
    load(12'h123);
    frame("race1", 16, 1'b1, 12'h456);
    frame("race2", 16, 1'b0, 12'h0);
    frame("extra", 18, 1'b0, 12'h0);
    // Reset in the middle of a frame, released while scs is still low.
    begin
      int a0;
      a0 = abort_cnt;
      scs = 1'b0; #HP;
      for (int i = 0; i < 5; i++) begin sck = 1'b0; #HP; sck = 1'b1; #HP; end
      rst_n = 1'b0; #1;
      chk("midrst.oe", sda_oe, 0);
      chk("midrst.busy", busy, 0);
      #(HP - 1); rst_n = 1'b1; #(4 * HP);
      chk("lowrel.busy", busy, 0);
      scs = 1'b1; #(2 * HP);
      chk("midrst.abort", abort_cnt - a0, 0);
      model_src = '0;
    end
    frame("post_rst", 16, 1'b0, 12'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
